register_file_scoreboard: RTL and testbench

- Responder end of the register-file interface: the 32-entry integer register file plus a per-register pending-write scoreboard.
- Serves the decode stage's two combinational read ports and ready flags.
- Accepts the decode stage's issue-time destination reservation and the write-back stage's commit write.
- Sits between DecodeStage and WriteBackStage; it is the only state holder for architectural integer registers.

---
 rtl/register_file_scoreboard_pkg.sv | 19 +
 rtl/register_file_scoreboard_if.sv | 33 +++
 rtl/register_file_scoreboard_pending_counter.sv | 38 +++
 rtl/register_file_scoreboard.sv | 89 ++++++++
 tb/tb_register_file_scoreboard.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_scoreboard_pkg.sv
// Shared types and constants for the integer register file and its
// pending-write scoreboard.
package register_file_scoreboard_pkg;

  localparam int unsigned REG_NUM       = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH    = 5;
  localparam int unsigned PENDING_WIDTH = 2;

  typedef logic [ADDR_WIDTH-1:0]    RegAddr;
  typedef logic [DATA_WIDTH-1:0]    BasicData;
  typedef logic [PENDING_WIDTH-1:0] PendingCount;

  // Largest number of writes that may be in flight to one register.
  localparam PendingCount PENDING_MAX = '1;

  localparam RegAddr ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Decode/write-back facing bundle of the register file. The master side is
// the pipeline (decode + write-back), the slave side is the register file.
interface register_file_scoreboard_if;
  import register_file_scoreboard_pkg::*;

  // Decode-stage read ports
  RegAddr   rs1Addr;
  RegAddr   rs2Addr;
  BasicData rs1Data;
  BasicData rs2Data;
  logic     rs1Ready;
  logic     rs2Ready;

  // Decode-stage destination reservation
  logic     prevWEnable;
  RegAddr   prevRdAddr;

  // Write-back commit
  logic     wEnable;
  RegAddr   rdAddr;
  BasicData wData;

  modport master (
    output rs1Addr, rs2Addr, prevWEnable, prevRdAddr, wEnable, rdAddr, wData,
    input  rs1Data, rs2Data, rs1Ready, rs2Ready
  );

  modport slave (
    input  rs1Addr, rs2Addr, prevWEnable, prevRdAddr, wEnable, rdAddr, wData,
    output rs1Data, rs2Data, rs1Ready, rs2Ready
  );

endinterface

// File: rtl/register_file_scoreboard_pending_counter.sv
// Saturating up/down counter tracking outstanding writes to one register.
// Simultaneous inc and dec cancel; inc at max and dec at zero hold.
module register_pending_counter
  import register_file_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        dec_i,
  output PendingCount count_o,
  output logic        is_zero_o,
  output logic        is_one_o
);

  PendingCount count_q;
  PendingCount count_d;

  // Next count: net change of +1, -1 or 0, clamped at both ends.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      if (count_q != PENDING_MAX) count_d = count_q + PendingCount'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q != '0) count_d = count_q - PendingCount'(1);
    end
  end

  // Counter register; reset drops all reservations.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o   = count_q;
  assign is_zero_o = (count_q == '0);
  assign is_one_o  = (count_q == PendingCount'(1));

endmodule

// File: rtl/register_file_scoreboard.sv
// Architectural integer register file with write-through bypass and a
// per-register pending-write scoreboard driving the decode ready flags.
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  register_file_scoreboard_if.slave   rf
);

  // x0 is hardwired, so storage and counters only exist for x1..x31.
  BasicData reg_q [1:REG_NUM-1];

  PendingCount pend_count [1:REG_NUM-1];
  logic        pend_zero  [1:REG_NUM-1];
  logic        pend_one   [1:REG_NUM-1];

  logic issue_valid;
  logic commit_valid;

  assign issue_valid  = rf.prevWEnable && (rf.prevRdAddr != ZERO_REG);
  assign commit_valid = rf.wEnable     && (rf.rdAddr     != ZERO_REG);

  // Register storage: cleared by reset, otherwise written on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) reg_q[i] <= '0;
    end else if (commit_valid) begin
      reg_q[rf.rdAddr] <= rf.wData;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < REG_NUM; gi++) begin : g_pend
      logic inc;
      logic dec;

      assign inc = issue_valid  && (rf.prevRdAddr == RegAddr'(gi));
      assign dec = commit_valid && (rf.rdAddr     == RegAddr'(gi));

      register_pending_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (inc),
        .dec_i     (dec),
        .count_o   (pend_count[gi]),
        .is_zero_o (pend_zero[gi]),
        .is_one_o  (pend_one[gi])
      );

      // Issuing a write to a register already at its in-flight limit.
      assert property (@(posedge clk) disable iff (rst)
                       !(inc && !dec && pend_count[gi] == PENDING_MAX))
        else $warning("pending counter overflow on x%0d", gi);

      // Committing a write that was never reserved.
      assert property (@(posedge clk) disable iff (rst)
                       !(dec && !inc && pend_zero[gi]))
        else $warning("pending counter underflow on x%0d", gi);
    end
  endgenerate

  // Source 1 read: x0 reads zero, a same-cycle commit is bypassed, and the
  // register is ready when nothing is pending or its last write retires now.
  always_comb begin
    rf.rs1Data  = '0;
    rf.rs1Ready = 1'b1;
    if (rf.rs1Addr != ZERO_REG) begin
      if (rf.wEnable && rf.rdAddr == rf.rs1Addr) rf.rs1Data = rf.wData;
      else                                       rf.rs1Data = reg_q[rf.rs1Addr];
      rf.rs1Ready = pend_zero[rf.rs1Addr] ||
                    (pend_one[rf.rs1Addr] && rf.wEnable && rf.rdAddr == rf.rs1Addr);
    end
  end

  // Source 2 read: same rules as source 1.
  always_comb begin
    rf.rs2Data  = '0;
    rf.rs2Ready = 1'b1;
    if (rf.rs2Addr != ZERO_REG) begin
      if (rf.wEnable && rf.rdAddr == rf.rs2Addr) rf.rs2Data = rf.wData;
      else                                       rf.rs2Data = reg_q[rf.rs2Addr];
      rf.rs2Ready = pend_zero[rf.rs2Addr] ||
                    (pend_one[rf.rs2Addr] && rf.wEnable && rf.rdAddr == rf.rs2Addr);
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: each task drives one scenario
// and compares read data / ready flags against hand-computed values.
module tb_register_file_scoreboard;
  import register_file_scoreboard_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  register_file_scoreboard_if rf ();

  register_file_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then move 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.prevWEnable = 1'b0;
    rf.prevRdAddr  = '0;
    rf.wEnable     = 1'b0;
    rf.rdAddr      = '0;
    rf.wData       = '0;
  endtask

  task automatic test_reset();
    idle();
    rf.rs1Addr = '0;
    rf.rs2Addr = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rf.rs1Addr = RegAddr'(i);
      rf.rs2Addr = RegAddr'(31 - i);
      #1;
      n_cmp++;
      if (rf.rs1Data !== 32'h0 || rf.rs1Ready !== 1'b1 ||
          rf.rs2Data !== 32'h0 || rf.rs2Ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_x%0d: got d1=%h r1=%b d2=%h r2=%b required d=0 r=1",
                 i, rf.rs1Data, rf.rs1Ready, rf.rs2Data, rf.rs2Ready);
      end
    end
    $display("reset: x0..x31 checked");
  endtask

  task automatic test_basic_write_read();
    rf.rs1Addr     = 5'd5;
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd5;
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_pre_issue_ready: got %b required 1", rf.rs1Ready);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pending_ready: got %b required 0", rf.rs1Ready);
    end
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd5;
    rf.wData   = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (rf.rs1Data !== 32'hDEADBEEF || rf.rs1Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_bypass: got d=%h r=%b required d=deadbeef r=1",
               rf.rs1Data, rf.rs1Ready);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Data !== 32'hDEADBEEF || rf.rs1Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_stored: got d=%h r=%b required d=deadbeef r=1",
               rf.rs1Data, rf.rs1Ready);
    end
    $display("basic: x5 issue/commit 0xdeadbeef");
  endtask

  task automatic test_multiple_in_flight();
    rf.rs2Addr     = 5'd7;
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd7;
    tick();
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs2Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_pend2_ready: got %b required 0", rf.rs2Ready);
    end
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd7;
    rf.wData   = 32'h11;
    #1;
    n_cmp++;
    if (rf.rs2Data !== 32'h11 || rf.rs2Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_first_wb: got d=%h r=%b required d=11 r=0",
               rf.rs2Data, rf.rs2Ready);
    end
    tick();
    rf.wData = 32'h22;
    #1;
    n_cmp++;
    if (rf.rs2Data !== 32'h22 || rf.rs2Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL multi_second_wb: got d=%h r=%b required d=22 r=1",
               rf.rs2Data, rf.rs2Ready);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs2Data !== 32'h22 || rf.rs2Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL multi_settled: got d=%h r=%b required d=22 r=1",
               rf.rs2Data, rf.rs2Ready);
    end
    $display("multi: x7 two in flight, retired 0x11 then 0x22");
  endtask

  task automatic test_simultaneous_inc_dec();
    rf.rs1Addr     = 5'd3;
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd3;
    tick();
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd3;
    rf.wData   = 32'h55;
    #1;
    n_cmp++;
    if (rf.rs1Data !== 32'h55 || rf.rs1Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_same_cycle: got d=%h r=%b required d=55 r=1",
               rf.rs1Data, rf.rs1Ready);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Data !== 32'h55 || rf.rs1Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_after: got d=%h r=%b required d=55 r=0",
               rf.rs1Data, rf.rs1Ready);
    end
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd3;
    rf.wData   = 32'h66;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Data !== 32'h66 || rf.rs1Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_retired: got d=%h r=%b required d=66 r=1",
               rf.rs1Data, rf.rs1Ready);
    end
    $display("simul: x3 inc+dec same cycle kept pend=1");
  endtask

  task automatic test_independent_regs();
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd11;
    tick();
    rf.prevRdAddr = 5'd10;
    rf.wEnable    = 1'b1;
    rf.rdAddr     = 5'd11;
    rf.wData      = 32'hAB;
    tick();
    idle();
    rf.rs1Addr = 5'd10;
    rf.rs2Addr = 5'd11;
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b0 || rf.rs2Ready !== 1'b1 || rf.rs2Data !== 32'hAB) begin
      n_bad++;
      $display("FAIL indep: got r10=%b r11=%b d11=%h required r10=0 r11=1 d11=ab",
               rf.rs1Ready, rf.rs2Ready, rf.rs2Data);
    end
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd10;
    rf.wData   = 32'hCD;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b1 || rf.rs1Data !== 32'hCD) begin
      n_bad++;
      $display("FAIL indep_x10_retire: got r=%b d=%h required r=1 d=cd",
               rf.rs1Ready, rf.rs1Data);
    end
    $display("indep: inc x10 with dec x11 in one cycle");
  endtask

  task automatic test_x0();
    rf.rs1Addr     = 5'd0;
    rf.rs2Addr     = 5'd0;
    rf.wEnable     = 1'b1;
    rf.rdAddr      = 5'd0;
    rf.wData       = 32'hFFFFFFFF;
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (rf.rs1Data !== 32'h0 || rf.rs1Ready !== 1'b1 ||
          rf.rs2Data !== 32'h0 || rf.rs2Ready !== 1'b1) begin
        n_bad++;
        $display("FAIL x0_cycle%0d: got d1=%h r1=%b d2=%h r2=%b required d=0 r=1",
                 c, rf.rs1Data, rf.rs1Ready, rf.rs2Data, rf.rs2Ready);
      end
      tick();
      if (c == 1) idle();
    end
    $display("x0: writes and reservations to x0 ignored");
  endtask

  task automatic test_reset_mid_operation();
    rf.rs1Addr     = 5'd9;
    rf.rs2Addr     = 5'd5;
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd9;
    tick();
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_pend2_ready: got %b required 0", rf.rs1Ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b1 || rf.rs1Data !== 32'h0 || rf.rs2Data !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_after_reset: got r9=%b d9=%h d5=%h required r9=1 d=0",
               rf.rs1Ready, rf.rs1Data, rf.rs2Data);
    end
    // Unreserved commit: data lands, counter must stay at zero.
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd9;
    rf.wData   = 32'h99;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b1 || rf.rs1Data !== 32'h99) begin
      n_bad++;
      $display("FAIL mid_underflow_hold: got r=%b d=%h required r=1 d=99",
               rf.rs1Ready, rf.rs1Data);
    end
    // One reservation must now give pend=1: not ready, then retire-ready.
    rf.prevWEnable = 1'b1;
    rf.prevRdAddr  = 5'd9;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_pend1_ready: got %b required 0", rf.rs1Ready);
    end
    rf.wEnable = 1'b1;
    rf.rdAddr  = 5'd9;
    rf.wData   = 32'h77;
    #1;
    n_cmp++;
    if (rf.rs1Ready !== 1'b1 || rf.rs1Data !== 32'h77) begin
      n_bad++;
      $display("FAIL mid_pend1_retire: got r=%b d=%h required r=1 d=77",
               rf.rs1Ready, rf.rs1Data);
    end
    tick();
    idle();
    $display("mid: reset cleared x9 reservations and x5 data");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    rf.rs1Addr = '0;
    rf.rs2Addr = '0;
    idle();
    tick();
    test_reset();
    test_basic_write_read();
    test_multiple_in_flight();
    test_simultaneous_inc_dec();
    test_independent_regs();
    test_x0();
    test_reset_mid_operation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
